i_cache_dm: RTL

- Parametrised direct-mapped instruction cache; successor to the flat preloaded instruction store.
- Sits between the fetch stage and a single-port backing instruction memory.
- Hits return in 1 cycle. Misses stall fetch while a multi-word line refill runs over a one-outstanding request/valid handshake.
- Keeps the nop bubble insertion; adds flush.

---
 rtl/i_cache_pkg.sv | 25 ++
 rtl/i_cache_tag_array.sv | 50 +++++
 rtl/i_cache_dm.sv | 169 ++++++++++++++++
 3 files changed

// File: rtl/i_cache_pkg.sv
// rtl/i_cache_pkg.sv - shared state encoding and geometry helpers for the direct-mapped instruction cache
package i_cache_pkg;

    localparam int DEF_ADDR_W   = 16;
    localparam int DEF_DATA_W   = 16;
    localparam int DEF_INDEX_W  = 6;
    localparam int DEF_OFFSET_W = 2;
    localparam int DEF_TAG_W    = DEF_ADDR_W - DEF_INDEX_W - DEF_OFFSET_W;

    typedef enum logic [1:0] {
        IDLE        = 2'd0,
        REFILL_REQ  = 2'd1,
        REFILL_WAIT = 2'd2,
        RESPOND     = 2'd3
    } state_e;

    function automatic int tag_width(input int addr_w, input int index_w, input int offset_w);
        return addr_w - index_w - offset_w;
    endfunction

    function automatic int line_words(input int offset_w);
        return 1 << offset_w;
    endfunction

endpackage

// File: rtl/i_cache_tag_array.sv
// rtl/i_cache_tag_array.sv - per-line valid bits and tags with single-cycle flush, lookup and write
module i_cache_tag_array
    import i_cache_pkg::*;
#(
    parameter int INDEX_W = DEF_INDEX_W,
    parameter int TAG_W   = DEF_TAG_W
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               flush,
    input  logic [INDEX_W-1:0] lookup_index,
    input  logic [TAG_W-1:0]   lookup_tag,
    output logic               hit,
    input  logic               wr_en,
    input  logic [INDEX_W-1:0] wr_index,
    input  logic [TAG_W-1:0]   wr_tag
);

    localparam int LINES = 2 ** INDEX_W;

    logic [LINES-1:0] valid_q, valid_d;
    logic [TAG_W-1:0] tag_q [LINES];

    // Flush wins over a same-cycle fill so a pending flush never leaves a stale line behind.
    always_comb begin
        valid_d = valid_q;
        if (flush) begin
            valid_d = '0;
        end else if (wr_en) begin
            valid_d[wr_index] = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q <= '0;
        end else begin
            valid_q <= valid_d;
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en) begin
            tag_q[wr_index] <= wr_tag;
        end
    end

    assign hit = valid_q[lookup_index] && (tag_q[lookup_index] == lookup_tag);

endmodule

// File: rtl/i_cache_dm.sv
// rtl/i_cache_dm.sv - direct-mapped instruction cache: 1-cycle hits, word-by-word line refill on miss
module i_cache_dm
    import i_cache_pkg::*;
#(
    parameter int ADDR_W   = DEF_ADDR_W,
    parameter int DATA_W   = DEF_DATA_W,
    parameter int INDEX_W  = DEF_INDEX_W,
    parameter int OFFSET_W = DEF_OFFSET_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              rd_en,
    input  logic [ADDR_W-1:0] rd_dest,
    input  logic              nop,
    input  logic              flush,
    output logic [DATA_W-1:0] rd_out,
    output logic [ADDR_W-1:0] pc_out,
    output logic              rd_valid,
    output logic              stall,
    output logic              mem_req,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              mem_rvalid
);

    localparam int TAG_W      = tag_width(ADDR_W, INDEX_W, OFFSET_W);
    localparam int LINE_WORDS = line_words(OFFSET_W);
    localparam int LOW_W      = INDEX_W + OFFSET_W;

    state_e              state_q, state_d;
    logic [OFFSET_W-1:0] cnt_q, cnt_d;
    logic [ADDR_W-1:0]   miss_addr_q, miss_addr_d;
    logic                pend_q, pend_d;
    logic [DATA_W-1:0]   rd_out_q, rd_out_d;
    logic [ADDR_W-1:0]   pc_out_q, pc_out_d;
    logic                rd_valid_q, rd_valid_d;
    logic                stall_q, stall_d;
    logic                mem_req_q, mem_req_d;
    logic [ADDR_W-1:0]   mem_addr_q, mem_addr_d;

    logic                lookup_hit;
    logic                flush_all;
    logic                data_we;
    logic                tag_we;
    logic [DATA_W-1:0]   data_q [2 ** LOW_W];

    i_cache_tag_array #(
        .INDEX_W (INDEX_W),
        .TAG_W   (TAG_W)
    ) u_tags (
        .clk          (clk),
        .rst          (rst),
        .flush        (flush_all),
        .lookup_index (rd_dest[LOW_W-1:OFFSET_W]),
        .lookup_tag   (rd_dest[ADDR_W-1:LOW_W]),
        .hit          (lookup_hit),
        .wr_en        (tag_we),
        .wr_index     (miss_addr_q[LOW_W-1:OFFSET_W]),
        .wr_tag       (miss_addr_q[ADDR_W-1:LOW_W])
    );

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        miss_addr_d = miss_addr_q;
        pend_d      = pend_q;
        rd_out_d    = rd_out_q;
        pc_out_d    = pc_out_q;
        rd_valid_d  = 1'b0;
        flush_all   = 1'b0;
        data_we     = 1'b0;
        tag_we      = 1'b0;
        case (state_q)
            IDLE: begin
                flush_all = flush;
                if (nop) begin
                    rd_out_d   = '0;
                    rd_valid_d = 1'b1;
                    if (rd_en) begin
                        pc_out_d = rd_dest;
                    end
                end
                // A same-cycle flush forces the lookup to miss.
                if (rd_en) begin
                    if (lookup_hit && !flush) begin
                        if (!nop) begin
                            rd_out_d   = data_q[rd_dest[LOW_W-1:0]];
                            pc_out_d   = rd_dest;
                            rd_valid_d = 1'b1;
                        end
                    end else begin
                        state_d     = REFILL_REQ;
                        miss_addr_d = rd_dest;
                        cnt_d       = '0;
                    end
                end
            end
            REFILL_REQ: begin
                pend_d  = pend_q | flush;
                state_d = REFILL_WAIT;
            end
            REFILL_WAIT: begin
                pend_d = pend_q | flush;
                if (mem_rvalid) begin
                    data_we = 1'b1;
                    if (cnt_q == OFFSET_W'(LINE_WORDS - 1)) begin
                        tag_we  = 1'b1;
                        state_d = RESPOND;
                    end else begin
                        cnt_d   = cnt_q + OFFSET_W'(1);
                        state_d = REFILL_REQ;
                    end
                end
            end
            RESPOND: begin
                rd_out_d   = data_q[miss_addr_q[LOW_W-1:0]];
                pc_out_d   = miss_addr_q;
                rd_valid_d = 1'b1;
                flush_all  = pend_q | flush;
                pend_d     = 1'b0;
                state_d    = IDLE;
            end
            default: state_d = IDLE;
        endcase
        stall_d    = (state_d != IDLE);
        mem_req_d  = (state_d == REFILL_REQ);
        mem_addr_d = mem_req_d ? {miss_addr_d[ADDR_W-1:OFFSET_W], cnt_d} : '0;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            miss_addr_q <= '0;
            pend_q      <= 1'b0;
            rd_out_q    <= '0;
            pc_out_q    <= '0;
            rd_valid_q  <= 1'b0;
            stall_q     <= 1'b0;
            mem_req_q   <= 1'b0;
            mem_addr_q  <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            miss_addr_q <= miss_addr_d;
            pend_q      <= pend_d;
            rd_out_q    <= rd_out_d;
            pc_out_q    <= pc_out_d;
            rd_valid_q  <= rd_valid_d;
            stall_q     <= stall_d;
            mem_req_q   <= mem_req_d;
            mem_addr_q  <= mem_addr_d;
        end
    end

    always_ff @(posedge clk) begin
        if (data_we) begin
            data_q[{miss_addr_q[LOW_W-1:OFFSET_W], cnt_q}] <= mem_rdata;
        end
    end

    assign rd_out   = rd_out_q;
    assign pc_out   = pc_out_q;
    assign rd_valid = rd_valid_q;
    assign stall    = stall_q;
    assign mem_req  = mem_req_q;
    assign mem_addr = mem_addr_q;

endmodule
